// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter.
// The tag id field is sized for the largest supported requester count (8),
// so one tag type serves every legal NUM_REQ.
package mult_arb_pkg;

    localparam int OP_W    = 30;
    localparam int PROD_W  = 2 * OP_W;
    localparam int MAX_REQ = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int ID_W = id_w(MAX_REQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Single-grant arbiter for the shared multiplier.
// Default build: round-robin, the search starts at a pointer register that
// moves one past each winner. With MULT_ARB_FIXED_PRIO_EN defined the
// lowest-indexed valid requester always wins and no pointer exists.
// The grant is forced to zero while reset is asserted.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   gnt_id
);

    int   base_s;
    int   idx_s;
    logic found_s;

`ifdef MULT_ARB_FIXED_PRIO_EN
    assign base_s = 0;
`else
    logic [SEL_W-1:0] ptr_r;

    // Rotate the search start to one past the most recent winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (|gnt) begin
            if (int'(gnt_id) == NUM_REQ - 1) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= gnt_id + SEL_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign base_s = int'(ptr_r);
`endif

    // Pick the first valid requester at or after the search start, wrapping.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_s = (base_s + off) % NUM_REQ;
            if (!rst && !found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = SEL_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined modular multiplier among NUM_REQ butterfly lanes.
// One operand pair is granted per cycle and registered onto mul_a/mul_b;
// a tag pipe of depth MUL_LAT+1 follows each operation so the product on
// mul_p is steered back to its issuer exactly 1+MUL_LAT cycles after grant.
// Optional build macro: MULT_ARB_FIXED_PRIO_EN (fixed lowest-index priority).
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 30,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [2*OP_W-1:0]       mul_p,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [2*OP_W-1:0]       rsp_p,
    output logic                    busy
);

    localparam int SEL_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0] gnt_s;
    logic [SEL_W-1:0]   gnt_id_s;
    tag_t               tag_in_s;
    tag_t [MUL_LAT:0]   tag_pipe_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    assign req_ready = gnt_s;
    assign rsp_p     = mul_p;

    // Capture the granted operands; hold them when nothing is granted so the
    // multiplier inputs do not toggle needlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (|gnt_s) begin
            mul_a <= req_a[int'(gnt_id_s)*OP_W +: OP_W];
            mul_b <= req_b[int'(gnt_id_s)*OP_W +: OP_W];
        end else begin
            mul_a <= mul_a;
            mul_b <= mul_b;
        end
    end

    // Tag entering the pipe this cycle: valid only when a grant is made.
    always_comb begin
        tag_in_s     = '0;
        tag_in_s.vld = |gnt_s;
        tag_in_s.id  = ID_W'(gnt_id_s);
    end

    // Free-running tag shift register aligned with the multiplier latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe_r <= '0;
        end else begin
            tag_pipe_r[0] <= tag_in_s;
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    // Decode the oldest tag into a one-hot response strobe; busy covers all
    // operations already issued to the multiplier.
    always_comb begin
        rsp_valid = '0;
        busy      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_pipe_r[MUL_LAT].vld && (tag_pipe_r[MUL_LAT].id == ID_W'(i))) begin
                rsp_valid[i] = 1'b1;
            end else begin
                rsp_valid[i] = 1'b0;
            end
        end
        for (int i = 0; i <= MUL_LAT; i++) begin
            busy = busy | tag_pipe_r[i].vld;
        end
    end

endmodule
